// File: rtl/winograd_pkg.sv
// Shared sizing helpers for the Winograd pipeline and the output writer state type.
package winograd_pkg;

   function automatic int out_tile_f(input int tile_size, input int kernel_size);
      return tile_size - kernel_size + 1;
   endfunction

   function automatic int out_w_f(input int image_width, input int kernel_size);
      return image_width - kernel_size + 1;
   endfunction

   function automatic int psum_w_f(input int kernel_data_width, input int input_data_width);
      return kernel_data_width + input_data_width + 13;
   endfunction

   function automatic int acc_w_f(input int psum_w, input int channels);
      return psum_w + $clog2(channels);
   endfunction

   function automatic int addr_w_f(input int out_w);
      return $clog2(out_w * out_w);
   endfunction

   // Counter width that never collapses to zero bits for a count of one.
   function automatic int cnt_w_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      ST_ACC,
      ST_WR
   } state_t;

endpackage

// File: rtl/output_tile_addr_gen.sv
// Walks the element position inside an output tile and the tile position across the frame,
// producing the address of the next write and a one-cycle frame completion pulse.
module output_tile_addr_gen
   import winograd_pkg::*;
#(
   parameter int OUT_TILE = 2,
   parameter int OUT_W    = 8,
   parameter int ADDR_W   = 6
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       start,
   input  logic                                       advance,
   output logic [ADDR_W-1:0]                          addr_next,
   output logic [cnt_w_f(OUT_TILE*OUT_TILE)-1:0]      elem_next,
   output logic                                       last_elem,
   output logic                                       frame_done
);

   localparam int TPR  = OUT_W / OUT_TILE;
   localparam int RC_W = cnt_w_f(OUT_TILE);
   localparam int T_W  = cnt_w_f(TPR);
   localparam int EL_W = cnt_w_f(OUT_TILE * OUT_TILE);

   logic [RC_W-1:0] r, c, nr, nc;
   logic [T_W-1:0]  trow, tcol;
   logic            last_col, last_tcol, last_tile;

   assign last_col  = (c == RC_W'(OUT_TILE - 1));
   assign last_elem = last_col && (r == RC_W'(OUT_TILE - 1));
   assign last_tcol = (tcol == T_W'(TPR - 1));
   assign last_tile = last_tcol && (trow == T_W'(TPR - 1));

   // Pick the element that will be presented on the write port after this edge.
   always_comb begin
      nr = r;
      nc = c;
      if (start) begin
         nr = '0;
         nc = '0;
      end else if (last_col) begin
         nr = r + RC_W'(1);
         nc = '0;
      end else begin
         nc = c + RC_W'(1);
      end
      addr_next = ADDR_W'((int'(trow) * OUT_TILE + int'(nr)) * OUT_W + int'(tcol) * OUT_TILE + int'(nc));
      elem_next = EL_W'(int'(nr) * OUT_TILE + int'(nc));
   end

   // Element and tile counters; the tile moves on once its last element has been written.
   always_ff @(posedge clk) begin
      if (reset) begin
         r          <= '0;
         c          <= '0;
         trow       <= '0;
         tcol       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (start) begin
            r <= '0;
            c <= '0;
         end else if (advance) begin
            if (last_elem) begin
               r          <= '0;
               c          <= '0;
               frame_done <= last_tile;
               if (last_tcol) begin
                  tcol <= '0;
                  trow <= last_tile ? '0 : trow + T_W'(1);
               end else begin
                  tcol <= tcol + T_W'(1);
               end
            end else begin
               r <= nr;
               c <= nc;
            end
         end
      end
   end

endmodule

// File: rtl/winograd_output_tile_writer.sv
// Sums the per-channel partial tiles of one output tile position and streams the result
// into the output image memory in raster order, one element per cycle.
module winograd_output_tile_writer
   import winograd_pkg::*;
#(
   parameter int KERNEL_SIZE       = 3,
   parameter int INPUT_IMAGE_WIDTH = 10,
   parameter int INPUT_TILE_SIZE   = 4,
   parameter int INPUT_DATA_WIDTH  = 8,
   parameter int KERNEL_DATA_WIDTH = 8,
   parameter int CHANNELS          = 3,
   localparam int OUT_TILE = out_tile_f(INPUT_TILE_SIZE, KERNEL_SIZE),
   localparam int OUT_W    = out_w_f(INPUT_IMAGE_WIDTH, KERNEL_SIZE),
   localparam int PSUM_W   = psum_w_f(KERNEL_DATA_WIDTH, INPUT_DATA_WIDTH),
   localparam int ACC_W    = acc_w_f(PSUM_W, CHANNELS),
   localparam int ADDR_W   = addr_w_f(OUT_W)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [OUT_TILE*OUT_TILE*PSUM_W-1:0] in_tile,
   output logic                                wr_en,
   output logic [ADDR_W-1:0]                   wr_addr,
   output logic signed [ACC_W-1:0]             wr_data,
   output logic                                frame_done,
   output logic                                busy
);

   localparam int NELEM = OUT_TILE * OUT_TILE;
   localparam int CH_W  = cnt_w_f(CHANNELS);
   localparam int EL_W  = cnt_w_f(NELEM);

   if (OUT_W % OUT_TILE != 0) begin : g_param_check
      $error("OUT_W must be divisible by OUT_TILE");
   end

   state_t                  state, state_next;
   logic [CH_W-1:0]         ch;
   logic signed [ACC_W-1:0] acc      [NELEM];
   logic signed [ACC_W-1:0] acc_next [NELEM];
   logic                    accept, start, advance, last_elem;
   logic [ADDR_W-1:0]       addr_next;
   logic [EL_W-1:0]         elem_next;

   assign accept = in_valid && in_ready;
   assign start  = accept && (ch == CH_W'(CHANNELS - 1));
   assign busy   = (state == ST_WR) || (ch != '0);

   // The first channel seeds the accumulators, later channels add onto them.
   always_comb begin
      for (int i = 0; i < NELEM; i++) begin
         acc_next[i] = ACC_W'($signed(in_tile[i*PSUM_W +: PSUM_W]));
         if (ch != '0) begin
            acc_next[i] = acc[i] + acc_next[i];
         end
      end
   end

   // Accumulate until the final channel arrives, then spend one cycle per element writing.
   always_comb begin
      state_next = state;
      advance    = 1'b0;
      case (state)
         ST_ACC: begin
            if (start) begin
               state_next = ST_WR;
            end
         end
         ST_WR: begin
            advance = 1'b1;
            if (last_elem) begin
               state_next = ST_ACC;
            end
         end
         default: state_next = ST_ACC;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_ACC;
      end else begin
         state <= state_next;
      end
   end

   // Handshake, channel count, accumulators and the registered write port; element 0 is
   // launched straight from the incoming sum so the writes follow the last channel with no gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready <= 1'b0;
         ch       <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         for (int i = 0; i < NELEM; i++) begin
            acc[i] <= '0;
         end
      end else begin
         in_ready <= (state_next == ST_ACC);
         if (accept) begin
            for (int i = 0; i < NELEM; i++) begin
               acc[i] <= acc_next[i];
            end
            ch <= start ? '0 : ch + CH_W'(1);
         end
         if (start) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_next;
            wr_data <= acc_next[0];
         end else if (advance && !last_elem) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_next;
            wr_data <= acc[elem_next];
         end else begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
         end
      end
   end

   output_tile_addr_gen #(
      .OUT_TILE (OUT_TILE),
      .OUT_W    (OUT_W),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .advance    (advance),
      .addr_next  (addr_next),
      .elem_next  (elem_next),
      .last_elem  (last_elem),
      .frame_done (frame_done)
   );

endmodule

// File: tb/tb_winograd_output_tile_writer.sv
// Bench for the Winograd output tile writer: a tile-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_winograd_output_tile_writer;

   localparam int OT     = 2;
   localparam int NE     = 4;
   localparam int OUT_W  = 8;
   localparam int TPR    = 4;
   localparam int NTILES = 16;
   localparam int PW     = 29;
   localparam int AW     = 31;
   localparam int ADW    = 6;
   localparam int CH     = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [NE*PW-1:0] in_tile = '0;
   logic           wr_en;
   logic [ADW-1:0] wr_addr;
   logic [AW-1:0]  wr_data;
   logic           frame_done;
   logic           busy;

   int checks = 0;
   int errors = 0;

   winograd_output_tile_writer dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_tile    (in_tile),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one entry per pending write, derived from tile index and channel sums.
   typedef struct {
      int     addr;
      longint data;
      bit     last;
   } wr_t;

   wr_t    pend[$];
   int     m_ch = 0;
   int     m_tile = 0;
   longint m_sum[NE];
   bit     last_popped = 0;
   bit     e_ready = 0, e_busy = 0, e_en = 0, e_fd = 0;
   int     e_addr = 0;
   longint e_data = 0;

   int     log_addr[$];
   longint log_data[$];
   int     fd_count = 0;
   int     fd_prev_addr = -1;
   bit     fd_prev_en = 0;
   int     prev_addr = 0;
   bit     prev_en = 0;

   task automatic model_step();
      bit     hs;
      wr_t    w;
      longint v;
      if (reset) begin
         pend.delete();
         m_ch = 0;
         m_tile = 0;
         last_popped = 0;
         e_ready = 0; e_busy = 0; e_en = 0; e_fd = 0; e_addr = 0; e_data = 0;
         return;
      end
      hs = in_valid && e_ready;
      if (hs) begin
         for (int i = 0; i < NE; i++) begin
            v = longint'($signed(in_tile[i*PW +: PW]));
            m_sum[i] = (m_ch == 0) ? v : m_sum[i] + v;
         end
         m_ch++;
         if (m_ch == CH) begin
            m_ch = 0;
            for (int r = 0; r < OT; r++) begin
               for (int c = 0; c < OT; c++) begin
                  w.addr = ((m_tile / TPR) * OT + r) * OUT_W + (m_tile % TPR) * OT + c;
                  w.data = m_sum[r*OT + c];
                  w.last = (m_tile == NTILES - 1) && (r == OT - 1) && (c == OT - 1);
                  pend.push_back(w);
               end
            end
            m_tile = (m_tile + 1) % NTILES;
         end
      end
      e_fd = last_popped;
      last_popped = 0;
      if (pend.size() > 0) begin
         w = pend.pop_front();
         e_en = 1; e_addr = w.addr; e_data = w.data; last_popped = w.last;
      end else begin
         e_en = 0; e_addr = 0; e_data = 0;
      end
      e_ready = !e_en;
      e_busy = e_en || (m_ch != 0);
   endtask

   // Compare every output against the model once per cycle, log writes, then advance the model.
   initial begin
      forever begin
         @(negedge clk);
         check_output("in_ready",   longint'(in_ready),   longint'(e_ready));
         check_output("busy",       longint'(busy),       longint'(e_busy));
         check_output("wr_en",      longint'(wr_en),      longint'(e_en));
         check_output("frame_done", longint'(frame_done), longint'(e_fd));
         check_output("wr_addr",    longint'(wr_addr),    longint'(e_addr));
         check_output("wr_data",    longint'($signed(wr_data)), e_data);
         if (wr_en === 1'b1) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(longint'($signed(wr_data)));
         end
         if (frame_done === 1'b1) begin
            fd_count++;
            fd_prev_en = prev_en;
            fd_prev_addr = prev_addr;
         end
         prev_en = (wr_en === 1'b1);
         prev_addr = int'(wr_addr);
         model_step();
      end
   end

   task automatic apply_stimulus(input longint e0, input longint e1, input longint e2,
                                 input longint e3, input int gap);
      logic got;
      int   n;
      got = 1'b0;
      n = 0;
      in_tile = {e3[PW-1:0], e2[PW-1:0], e1[PW-1:0], e0[PW-1:0]};
      in_valid = 1'b1;
      while (!got) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!got && n > 50) begin
            check_output("handshake_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
      end
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_const_tile(input longint k);
      for (int i = 0; i < CH; i++) begin
         apply_stimulus(k, k, k, k, 0);
      end
   endtask

   task automatic settle();
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
   endtask

   task automatic check_write(input string name, input int idx, input int exp_addr, input longint exp_data);
      if (idx >= log_addr.size()) begin
         check_output({name, "_missing"}, log_addr.size(), idx + 1);
      end else begin
         check_output({name, "_addr"}, log_addr[idx], exp_addr);
         check_output({name, "_data"}, log_data[idx], exp_data);
      end
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int     base;
      int     fd0;
      int     covered;
      int     hits[64];
      int     a1[4];
      int     a2[4];
      int     a5[4];
      longint mix[4];
      longint neg;

      a1 = '{0, 1, 8, 9};
      a2 = '{2, 3, 10, 11};
      a5 = '{18, 19, 26, 27};
      mix = '{15, -21, 0, 300};
      neg = -64'sd268435456;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_output("reset_in_ready", longint'(in_ready), 0);
      check_output("reset_wr_en", longint'(wr_en), 0);
      check_output("reset_busy", longint'(busy), 0);

      // Tile 0: channels of 1, 2, 3 sum to 6.
      base = log_addr.size();
      apply_stimulus(1, 1, 1, 1, 0);
      apply_stimulus(2, 2, 2, 2, 0);
      apply_stimulus(3, 3, 3, 3, 0);
      settle();
      for (int i = 0; i < 4; i++) check_write("t1", base + i, a1[i], 6);
      check_output("t1_frame_done", fd_count, 0);

      // Tile 1: most negative-ish partials, three times.
      base = log_addr.size();
      send_const_tile(neg);
      settle();
      for (int i = 0; i < 4; i++) check_write("t2_neg", base + i, a2[i], -64'sd805306368);

      // Tile 2: mixed signs.
      base = log_addr.size();
      for (int i = 0; i < CH; i++) apply_stimulus(5, -7, 0, 100, 0);
      settle();
      for (int i = 0; i < 4; i++) check_write("t2_mix", base + i, 4 + (i / 2) * 8 + (i % 2), mix[i]);

      // Tile 3: reset after two of three channels.
      apply_stimulus(4, 4, 4, 4, 0);
      apply_stimulus(4, 4, 4, 4, 0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_output("t5_busy", longint'(busy), 0);
      check_output("t5_wr_en", longint'(wr_en), 0);
      check_output("t5_in_ready", longint'(in_ready), 0);
      check_output("t5_frame_done", longint'(frame_done), 0);
      reset = 1'b0;

      // Full frame after reset, tile t carries constant t.
      base = log_addr.size();
      fd0 = fd_count;
      for (int t = 0; t < NTILES; t++) send_const_tile(t);
      settle();
      for (int i = 0; i < 64; i++) hits[i] = 0;
      for (int i = 0; i < 64 && base + i < log_addr.size(); i++) hits[log_addr[base + i]]++;
      covered = 0;
      for (int i = 0; i < 64; i++) if (hits[i] == 1) covered++;
      check_output("t3_cover", covered, 64);
      check_write("t3_tile0", base, 0, 0);
      for (int i = 0; i < 4; i++) check_write("t3_tile5", base + 20 + i, a5[i], 15);
      check_output("t3_fd_count", fd_count - fd0, 1);
      check_output("t3_fd_prev_en", longint'(fd_prev_en), 1);
      check_output("t3_fd_prev_addr", fd_prev_addr, 63);

      // Next frame restarts at address 0 without reset.
      base = log_addr.size();
      send_const_tile(7);
      settle();
      check_write("t3_restart", base, 0, 21);

      // Continuous in_valid across two tiles with distinct channel data.
      base = log_addr.size();
      apply_stimulus(10, -20, 30, -40, 0);
      apply_stimulus(1, 2, 3, 4, 0);
      apply_stimulus(-100, 0, 50, 7, 0);
      apply_stimulus(9, 9, 9, 9, 0);
      apply_stimulus(-1, -1, -1, -1, 0);
      apply_stimulus(2, 2, 2, 2, 0);
      settle();
      check_write("t4_e0", base + 0, 2, -89);
      check_write("t4_e1", base + 1, 3, -18);
      check_write("t4_e2", base + 2, 10, 83);
      check_write("t4_e3", base + 3, 11, -29);
      check_write("t4_next", base + 4, 4, 10);

      // Gaps between channels keep busy asserted.
      apply_stimulus(1, 1, 1, 1, 3);
      check_output("t6_busy_gap0", longint'(busy), 1);
      apply_stimulus(1, 1, 1, 1, 2);
      check_output("t6_busy_gap1", longint'(busy), 1);
      apply_stimulus(1, 1, 1, 1, 0);
      for (int t = 0; t < 4; t++) begin
         for (int ch = 0; ch < CH; ch++) begin
            apply_stimulus(longint'($urandom_range(0, 2000)) - 1000,
                           longint'($urandom_range(0, 2000)) - 1000,
                           longint'($urandom_range(0, 2000)) - 1000,
                           longint'($urandom_range(0, 2000)) - 1000,
                           int'($urandom_range(0, 3)));
         end
      end
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
